sys_mac_pe: RTL and testbench

Parametrised output-stationary systolic processing element for the TPU array, successor to the fixed 8-bit MAC cell. Each cycle it forwards left/top operands with valid and tile-framing sidebands, multiplies signed operands, accumulates over a framed tile, then hands the finished sum to a per-column valid/ready drain chain. The drain chain lets results leave the array while the next tile streams in.

---
 rtl/sys_mac_pkg.sv | 22 ++
 rtl/sys_mac_pe_if.sv | 43 ++++
 rtl/sys_mac_drain.sv | 61 ++++++
 rtl/sys_mac_pe.sv | 106 ++++++++++
 tb/tb_sys_mac_pe.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/sys_mac_pkg.sv
// Shared definitions for the systolic MAC processing element.
//   - DEF_DATA_W / DEF_ACC_W : default operand / accumulator widths
//   - mac_st_e               : compute FSM state (IDLE, ACC)
//   - sat_max / sat_min      : signed range limits for a w-bit accumulator,
//                              returned in 64 bits (truncate at the caller)
package sys_mac_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ACC_W  = 32;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } mac_st_e;

  function automatic logic signed [63:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction
endpackage

// File: rtl/sys_mac_pe_if.sv
// Bus bundle around one systolic MAC PE.
//   slave  : the PE's view (operand/drain inputs in, forwarded copies and
//            drain outputs out)
//   master : the environment's view (neighbours / bench)
// Operands: in_left* / in_top* -> out_right* / out_bottom*
// Drain   : in_res/in_res_valid/in_res_ready from above,
//           out_res/out_res_valid/out_res_ready toward below
// Status  : waitrequest (compute stall), err_ovf (sticky result loss)
interface sys_mac_pe_if import sys_mac_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
);
  logic              waitrequest;
  logic [DATA_W-1:0] in_left;
  logic              in_left_valid, in_left_first, in_left_last;
  logic [DATA_W-1:0] in_top;
  logic              in_top_valid;
  logic [DATA_W-1:0] out_right;
  logic              out_right_valid, out_right_first, out_right_last;
  logic [DATA_W-1:0] out_bottom;
  logic              out_bottom_valid;
  logic [ACC_W-1:0]  in_res;
  logic              in_res_valid, in_res_ready;
  logic [ACC_W-1:0]  out_res;
  logic              out_res_valid, out_res_ready;
  logic              err_ovf;

  modport slave (
    input  waitrequest, in_left, in_left_valid, in_left_first, in_left_last,
           in_top, in_top_valid, in_res, in_res_valid, out_res_ready,
    output out_right, out_right_valid, out_right_first, out_right_last,
           out_bottom, out_bottom_valid, in_res_ready, out_res,
           out_res_valid, err_ovf
  );

  modport master (
    output waitrequest, in_left, in_left_valid, in_left_first, in_left_last,
           in_top, in_top_valid, in_res, in_res_valid, out_res_ready,
    input  out_right, out_right_valid, out_right_first, out_right_last,
           out_bottom, out_bottom_valid, in_res_ready, out_res,
           out_res_valid, err_ovf
  );
endinterface

// File: rtl/sys_mac_drain.sv
// Per-column result drain stage: one pending slot (res_pend) for this PE's
// finished tile plus one output register feeding the PE below.
//   pend_wr/pend_data         : finished tile sum from the local MAC
//   in_res/_valid/_ready      : results arriving from the PE above
//   out_res/_valid/_ready     : results leaving toward the PE below
//   err_ovf                   : sticky, a pending result was overwritten
// The local result always wins the output register, so a PE's own result
// leaves before anything queued above it. Also used by the bottom-edge
// collector, hence the plain (non-interface) ports.
module sys_mac_drain #(
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pend_wr,
  input  logic [ACC_W-1:0] pend_data,
  input  logic [ACC_W-1:0] in_res,
  input  logic             in_res_valid,
  output logic             in_res_ready,
  output logic [ACC_W-1:0] out_res,
  output logic             out_res_valid,
  input  logic             out_res_ready,
  output logic             err_ovf
);
  logic [ACC_W-1:0] pend;
  logic             pend_full;
  logic             load;

  assign load         = !out_res_valid || out_res_ready;
  assign in_res_ready = load && !pend_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_res       <= '0;
      out_res_valid <= 1'b0;
      pend          <= '0;
      pend_full     <= 1'b0;
      err_ovf       <= 1'b0;
    end else begin
      if (load) begin
        if (pend_full) begin
          out_res       <= pend;
          out_res_valid <= 1'b1;
        end else if (in_res_valid) begin
          out_res       <= in_res;
          out_res_valid <= 1'b1;
        end else begin
          out_res_valid <= 1'b0;
        end
      end
      if (pend_wr) begin
        pend      <= pend_data;
        pend_full <= 1'b1;
        // Loss only if the old entry is not moving out on this same edge.
        if (pend_full && !load) err_ovf <= 1'b1;
      end else if (load && pend_full) begin
        pend_full <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/sys_mac_pe.sv
// Output-stationary systolic MAC processing element.
//   clk, rst : clock, synchronous active-high reset
//   bus      : sys_mac_pe_if.slave (operands, forwarded copies, drain chain,
//              waitrequest, err_ovf)
// Operands are forwarded with 1-cycle latency on every non-stalled cycle.
// Beats (both valids, no waitrequest) accumulate signed products over a
// tile framed by first/last; the final sum goes to the drain stage.
// ACC_W must be >= 2*DATA_W.
// Build option: SYS_MAC_PE_SAT_EN defined -> saturating accumulate,
// otherwise two's-complement wrap.
module sys_mac_pe import sys_mac_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input logic         clk,
  input logic         rst,
  sys_mac_pe_if.slave bus
);
  mac_st_e st, st_nxt;
  logic signed [2*DATA_W-1:0] l_ext, t_ext, prod;
  logic signed [ACC_W-1:0]    prod_ext, acc, acc_nxt, sum;
  logic                       beat, pend_wr;

  assign beat     = bus.in_left_valid && bus.in_top_valid && !bus.waitrequest;
  assign l_ext    = (2*DATA_W)'($signed(bus.in_left));
  assign t_ext    = (2*DATA_W)'($signed(bus.in_top));
  assign prod     = l_ext * t_ext;
  assign prod_ext = ACC_W'(prod);

`ifdef SYS_MAC_PE_SAT_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(sat_max(ACC_W));
  localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(sat_min(ACC_W));
  logic signed [ACC_W:0] wide;

  // One guard bit: overflow shows as guard != sign.
  always_comb begin
    wide = {acc[ACC_W-1], acc} + {prod_ext[ACC_W-1], prod_ext};
    if (wide[ACC_W] != wide[ACC_W-1]) sum = wide[ACC_W] ? ACC_MIN : ACC_MAX;
    else                              sum = wide[ACC_W-1:0];
  end
`else
  assign sum = acc + prod_ext;
`endif

  always_comb begin
    st_nxt  = st;
    acc_nxt = acc;
    pend_wr = 1'b0;
    if (beat) begin
      if (bus.in_left_first) begin
        acc_nxt = prod_ext;
        pend_wr = bus.in_left_last;
        st_nxt  = bus.in_left_last ? IDLE : ACC;
      end else if (st == ACC) begin
        acc_nxt = sum;
        if (bus.in_left_last) begin
          pend_wr = 1'b1;
          st_nxt  = IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st  <= IDLE;
      acc <= '0;
    end else begin
      st  <= st_nxt;
      acc <= acc_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_right        <= '0;
      bus.out_right_valid  <= 1'b0;
      bus.out_right_first  <= 1'b0;
      bus.out_right_last   <= 1'b0;
      bus.out_bottom       <= '0;
      bus.out_bottom_valid <= 1'b0;
    end else if (!bus.waitrequest) begin
      bus.out_right        <= bus.in_left;
      bus.out_right_valid  <= bus.in_left_valid;
      bus.out_right_first  <= bus.in_left_first;
      bus.out_right_last   <= bus.in_left_last;
      bus.out_bottom       <= bus.in_top;
      bus.out_bottom_valid <= bus.in_top_valid;
    end
  end

  // acc_nxt carries the final sum on the last beat.
  sys_mac_drain #(.ACC_W(ACC_W)) u_drain (
    .clk           (clk),
    .rst           (rst),
    .pend_wr       (pend_wr),
    .pend_data     (acc_nxt),
    .in_res        (bus.in_res),
    .in_res_valid  (bus.in_res_valid),
    .in_res_ready  (bus.in_res_ready),
    .out_res       (bus.out_res),
    .out_res_valid (bus.out_res_valid),
    .out_res_ready (bus.out_res_ready),
    .err_ovf       (bus.err_ovf)
  );
endmodule

// File: tb/tb_sys_mac_pe.sv
module tb_sys_mac_pe;
  localparam int DW = 8;
  localparam int AW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sys_mac_pe_if #(.DATA_W(DW), .ACC_W(AW)) bus ();
  sys_mac_pe #(.DATA_W(DW), .ACC_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;
  longint exp_q[$];

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint sx_d(input logic [DW-1:0] v);
    return longint'($signed(v));
  endfunction
  function automatic longint sx_a(input logic [AW-1:0] v);
    return longint'($signed(v));
  endfunction

  // Spec arithmetic on plain integers: accumulate then wrap or clamp.
  function automatic longint fold(input longint a, input longint p);
    longint s, hi, lo;
    logic [AW-1:0] t;
    s  = a + p;
    hi = (longint'(1) <<< (AW - 1)) - 1;
    lo = -(longint'(1) <<< (AW - 1));
`ifdef SYS_MAC_PE_SAT_EN
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
`else
    t = s[AW-1:0];
    return sx_a(t);
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input int l, input int t, input bit f, input bit la);
    bus.in_left_valid = v;
    bus.in_top_valid  = v;
    bus.in_left       = DW'(l);
    bus.in_top        = DW'(t);
    bus.in_left_first = f;
    bus.in_left_last  = la;
  endtask

  task automatic idle();
    drive(1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // random-phase model state
  bit     open_t = 1'b0;
  longint run_s  = 0;
  longint e_r, e_b;
  bit     e_rv, e_rf, e_rl, e_bv;

  initial begin
    bus.waitrequest   = 1'b0;
    bus.in_res        = '0;
    bus.in_res_valid  = 1'b0;
    bus.out_res_ready = 1'b1;
    idle();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_out_right", sx_d(bus.out_right), 0);
    chk("rst_out_right_valid", bus.out_right_valid, 0);
    chk("rst_out_bottom", sx_d(bus.out_bottom), 0);
    chk("rst_out_res_valid", bus.out_res_valid, 0);
    chk("rst_out_res", sx_a(bus.out_res), 0);
    chk("rst_err_ovf", bus.err_ovf, 0);
    rst = 1'b0;

    // ---- basic 3-beat tile ----
    drive(1, 2, 3, 1, 0);  tick();
    chk("fwd_right", sx_d(bus.out_right), 2);
    chk("fwd_bottom", sx_d(bus.out_bottom), 3);
    chk("fwd_first", bus.out_right_first, 1);
    chk("fwd_valid", bus.out_right_valid, 1);
    drive(1, -4, 5, 0, 0); tick();
    chk("fwd_right2", sx_d(bus.out_right), -4);
    chk("fwd_first2", bus.out_right_first, 0);
    drive(1, 7, -1, 0, 1); tick();
    chk("fwd_last", bus.out_right_last, 1);
    chk("basic_not_yet", bus.out_res_valid, 0);
    idle(); tick();
    chk("basic_valid", bus.out_res_valid, 1);
    chk("basic_sum", sx_a(bus.out_res), -21);
    tick();
    chk("basic_drained", bus.out_res_valid, 0);

    // ---- stall mid-tile with a previous result draining ----
    bus.out_res_ready = 1'b0;
    drive(1, 4, 4, 1, 1); tick();
    idle(); tick();
    chk("stall_prev_held", sx_a(bus.out_res), 16);
    drive(1, 2, 3, 1, 0);  tick();
    drive(1, -4, 5, 0, 0); tick();
    drive(1, 7, -1, 0, 1);
    bus.waitrequest   = 1'b1;
    bus.out_res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_fwd_frozen", sx_d(bus.out_right), -4);
      chk("stall_last_frozen", bus.out_right_last, 0);
      chk("stall_drain_done", bus.out_res_valid, 0);
    end
    bus.waitrequest = 1'b0;
    tick();
    idle(); tick();
    chk("stall_valid", bus.out_res_valid, 1);
    chk("stall_sum", sx_a(bus.out_res), -21);
    tick();

    // ---- drain chain priority ----
    bus.out_res_ready = 1'b0;
    drive(1, 2, 5, 1, 1); tick();
    idle();
    bus.in_res       = AW'(99);
    bus.in_res_valid = 1'b1;
    #1;
    chk("chain_ready_low_pend", bus.in_res_ready, 0);
    tick();
    chk("chain_own_first", sx_a(bus.out_res), 10);
    chk("chain_ready_low_full", bus.in_res_ready, 0);
    tick();
    chk("chain_hold", sx_a(bus.out_res), 10);
    chk("chain_hold_valid", bus.out_res_valid, 1);
    bus.out_res_ready = 1'b1;
    #1;
    chk("chain_ready_high", bus.in_res_ready, 1);
    tick();
    chk("chain_above", sx_a(bus.out_res), 99);
    bus.in_res_valid = 1'b0;
    tick();
    chk("chain_empty", bus.out_res_valid, 0);

    // ---- overflow: out reg busy, pend overwritten ----
    bus.out_res_ready = 1'b0;
    drive(1, 1, 1, 1, 1); tick();
    drive(1, 2, 2, 1, 1); tick();
    chk("ovf_none_yet", bus.err_ovf, 0);
    drive(1, 3, 3, 1, 1); tick();
    chk("ovf_set", bus.err_ovf, 1);
    idle();
    bus.out_res_ready = 1'b1;
    chk("ovf_out0", sx_a(bus.out_res), 1);
    tick();
    chk("ovf_out1_replaced", sx_a(bus.out_res), 9);
    tick();
    chk("ovf_empty", bus.out_res_valid, 0);
    chk("ovf_sticky", bus.err_ovf, 1);
    do_reset();
    chk("ovf_cleared", bus.err_ovf, 0);

    // ---- arithmetic limit ----
    drive(1, -128, -128, 1, 0); tick();
    drive(1, -128, -128, 0, 0); tick();
    drive(1, -128, -128, 0, 1); tick();
    idle(); tick();
`ifdef SYS_MAC_PE_SAT_EN
    chk("arith_limit", sx_a(bus.out_res), 32767);
`else
    chk("arith_limit", sx_a(bus.out_res), -16384);
`endif
    tick();

    // ---- reset mid-tile ----
    drive(1, 5, 5, 1, 0); tick();
    drive(1, 5, 5, 0, 0);
    bus.waitrequest = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.waitrequest = 1'b0;
    chk("midrst_right", sx_d(bus.out_right), 0);
    chk("midrst_bottom", sx_d(bus.out_bottom), 0);
    chk("midrst_valid", bus.out_right_valid, 0);
    chk("midrst_res_valid", bus.out_res_valid, 0);
    drive(1, 3, 3, 0, 1); tick();
    idle(); tick();
    chk("midrst_orphan_last", bus.out_res_valid, 0);
    tick();
    chk("midrst_orphan_last2", bus.out_res_valid, 0);
    drive(1, 3, 3, 1, 1); tick();
    idle(); tick();
    chk("midrst_fresh", sx_a(bus.out_res), 9);
    tick();

    // ---- randomized tiles vs integer model ----
    e_r = 0; e_b = 0; e_rv = 0; e_rf = 0; e_rl = 0; e_bv = 0;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      bit v, f, la, w, bt;
      int l, t;
      longint p;
      v  = ($urandom_range(0, 3) != 0);
      f  = ($urandom_range(0, 5) == 0);
      la = ($urandom_range(0, 4) == 0);
      w  = ($urandom_range(0, 3) == 0);
      l  = int'($urandom_range(0, 255)) - 128;
      t  = int'($urandom_range(0, 255)) - 128;
      drive(v, l, t, f, la);
      bus.waitrequest = w;
      if (!w) begin
        e_r = l; e_b = t; e_rv = v; e_rf = f; e_rl = la; e_bv = v;
      end
      bt = v && !w;
      if (bt) begin
        p = longint'(l) * longint'(t);
        if (f) begin
          run_s  = p;
          open_t = !la;
          if (la) exp_q.push_back(p);
        end else if (open_t) begin
          run_s = fold(run_s, p);
          if (la) begin
            exp_q.push_back(run_s);
            open_t = 1'b0;
          end
        end
      end
      tick();
      chk("rnd_right", sx_d(bus.out_right), e_r);
      chk("rnd_bottom", sx_d(bus.out_bottom), e_b);
      chk("rnd_flags", {bus.out_right_valid, bus.out_right_first, bus.out_right_last,
                        bus.out_bottom_valid}, {e_rv, e_rf, e_rl, e_bv});
      if (bus.out_res_valid) begin
        if (exp_q.size() == 0) chk("rnd_extra_result", 1, 0);
        else chk("rnd_result", sx_a(bus.out_res), exp_q.pop_front());
      end
    end
    idle();
    bus.waitrequest = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.out_res_valid) begin
        if (exp_q.size() == 0) chk("rnd_extra_result", 1, 0);
        else chk("rnd_result", sx_a(bus.out_res), exp_q.pop_front());
      end
    end
    chk("rnd_all_drained", exp_q.size(), 0);
    chk("rnd_no_ovf", bus.err_ovf, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
